// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left-justified serial transmitter with a 1-deep sample holding buffer.
// BCLK is generated from CLK by a divider; LRCLK, DIN and BCLK all change on the same CLK edge.
module i2s_stereo_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int CLK_DIV      = 4,
  parameter int JUSTIFY      = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [SAMPLE_WIDTH-1:0] SAMPLE_L,
  input  logic [SAMPLE_WIDTH-1:0] SAMPLE_R,
  input  logic                    SAMPLE_VALID,
  output logic                    SAMPLE_READY,
  input  logic                    MUTE,
  output logic                    UNDERRUN,
  output logic                    DAC_BCLK,
  output logic                    DAC_LRCLK,
  output logic                    DAC_DIN
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW    = $clog2(2 * SLOT_WIDTH);
  localparam int IW    = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam int LEAD  = (JUSTIFY == 0) ? 1 : 0;
  localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT_WIDTH - 1);

  logic [DIV_W-1:0]        div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    din_q, din_d;
  logic                    ready_q, ready_d;
  logic                    underrun_q, underrun_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;

  logic                    tick_s, fall_s, load_s, accept_s, lr_s, bit_s;
  logic [SAMPLE_WIDTH-1:0] cur_s;
  logic [IW-1:0]           sel_s;
  int                      bc_s, pos_s, idx_s;

  // Next-state logic: divider, bit counter, handshake, frame load and serial bit select
  always_comb begin
    tick_s   = (div_q == DIV_W'(CLK_DIV - 1));
    fall_s   = tick_s & bclk_q;
    load_s   = fall_s & (bit_q == LAST_BIT);
    accept_s = SAMPLE_VALID & ready_q;

    div_d       = tick_s ? '0 : div_q + DIV_W'(1);
    bclk_d      = tick_s ? ~bclk_q : bclk_q;
    bit_d       = bit_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;

    if (fall_s) begin
      bit_d = load_s ? '0 : bit_q + BW'(1);
    end else begin
      bit_d = bit_q;
    end

    // Muted frames still drain the holding buffer so the producer keeps its rate
    if (load_s) begin
      hold_full_d = 1'b0;
      if (hold_full_q && !MUTE) begin
        act_l_d = hold_l_q;
        act_r_d = hold_r_q;
      end else begin
        act_l_d = '0;
        act_r_d = '0;
      end
    end else begin
      hold_full_d = hold_full_q;
    end

    if (accept_s) begin
      hold_full_d = 1'b1;
      hold_l_d    = SAMPLE_L;
      hold_r_d    = SAMPLE_R;
    end else begin
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
    end

    ready_d    = ~hold_full_d;
    underrun_d = load_s & ~hold_full_q;

    bc_s  = int'(bit_d);
    lr_s  = (bc_s >= SLOT_WIDTH);
    pos_s = lr_s ? bc_s - SLOT_WIDTH : bc_s;
    idx_s = pos_s - LEAD;
    cur_s = lr_s ? act_r_d : act_l_d;
    sel_s = IW'(SAMPLE_WIDTH - 1 - idx_s);

    // With full-width I2S slots the previous slot's LSB spills into position 0
    if (idx_s >= 0 && idx_s < SAMPLE_WIDTH) begin
      bit_s = cur_s[sel_s];
    end else if (LEAD == 1 && SLOT_WIDTH == SAMPLE_WIDTH && pos_s == 0) begin
      bit_s = lr_s ? act_l_q[0] : act_r_q[0];
    end else begin
      bit_s = 1'b0;
    end

    lrclk_d = fall_s ? lr_s  : lrclk_q;
    din_d   = fall_s ? bit_s : din_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q       <= '0;
      bit_q       <= LAST_BIT;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b1;
      din_q       <= 1'b0;
      ready_q     <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
    end else begin
      div_q       <= div_d;
      bit_q       <= bit_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      din_q       <= din_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
    end
  end

  assign SAMPLE_READY = ready_q;
  assign UNDERRUN     = underrun_q;
  assign DAC_BCLK     = bclk_q;
  assign DAC_LRCLK    = lrclk_q;
  assign DAC_DIN      = din_q;

endmodule
